// File: rtl/json_stream_checker.sv
// rtl/json_stream_checker.sv - streaming JSON syntax checker, one byte per cycle, one status per document
// Nesting is a bit stack (1 = object, 0 = array); the first error of a document wins and the rest is drained.
module json_stream_checker #(
  parameter int  MAX_DEPTH = 16,
  parameter int  CNT_W     = 16,
  parameter int  ST_W      = 4,
  localparam int DW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             st_valid,
  input  logic             st_ready,
  output logic [ST_W-1:0]  st_code,
  output logic [CNT_W-1:0] st_offset,
  output logic [DW-1:0]    st_depth_max
);

  localparam logic [ST_W-1:0] ST_OK          = ST_W'(0);
  localparam logic [ST_W-1:0] ST_ROOT        = ST_W'(1);
  localparam logic [ST_W-1:0] ST_INVALID     = ST_W'(2);
  localparam logic [ST_W-1:0] ST_MISS_KEY    = ST_W'(3);
  localparam logic [ST_W-1:0] ST_MISS_COLON  = ST_W'(4);
  localparam logic [ST_W-1:0] ST_MISS_CURLY  = ST_W'(5);
  localparam logic [ST_W-1:0] ST_MISS_QUOTE  = ST_W'(6);
  localparam logic [ST_W-1:0] ST_MISS_SQUARE = ST_W'(7);
  localparam logic [ST_W-1:0] ST_NO_VALUE    = ST_W'(8);
  localparam logic [ST_W-1:0] ST_DEPTH       = ST_W'(10);

  localparam logic [DW-1:0]        D_ONE   = DW'(1);
  localparam logic [DW-1:0]        D_MAX   = DW'(MAX_DEPTH);
  localparam logic [MAX_DEPTH-1:0] STK_ONE = MAX_DEPTH'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    S_VALUE, S_KEY_OR_CLOSE, S_KEY, S_VALUE_OR_CLOSE, S_STR, S_ESC,
    S_COLON, S_LIT, S_NUM, S_AFTER, S_ROOT_DONE, S_DRAIN
  } state_e;

  state_e               state_q, state_d, eff0, eff, push_state;
  logic [MAX_DEPTH-1:0] stack_q, stack_d;
  logic [DW-1:0]        depth_q, depth_d, depth_max_q, depth_max_d;
  logic                 is_key_q, is_key_d;
  logic [1:0]           lit_kind_q, lit_kind_d;
  logic [2:0]           lit_idx_q, lit_idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc, off_q, off_d;
  logic [ST_W-1:0]      code_q, code_d, byte_code, end_code;
  logic                 err_q, err_d, st_valid_q, st_valid_d, run_q;
  logic                 accept, is_ws, is_digit, is_num, top_q, top_d;
  logic                 byte_err, push, push_obj, lit_done;
  logic [7:0]           lit_char;

  assign in_ready     = run_q & ~st_valid_q;
  assign accept       = in_valid & in_ready;
  assign st_valid     = st_valid_q;
  assign st_code      = code_q;
  assign st_offset    = off_q;
  assign st_depth_max = depth_max_q;

  assign is_ws    = (in_data == 8'h20) || (in_data == 8'h09) || (in_data == 8'h0A) || (in_data == 8'h0D);
  assign is_digit = (in_data >= "0") && (in_data <= "9");
  assign is_num   = is_digit || (in_data == ".") || (in_data == "e") || (in_data == "E") ||
                    (in_data == "+") || (in_data == "-");
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign top_q    = |(stack_q & (STK_ONE << (depth_q - D_ONE)));

  // Remaining characters of "true"/"false"/"null" after the first letter.
  always_comb begin
    lit_char = "u";
    lit_done = 1'b0;
    case (lit_kind_q)
      2'd0: begin
        case (lit_idx_q)
          3'd0:    lit_char = "r";
          3'd1:    lit_char = "u";
          default: lit_char = "e";
        endcase
        lit_done = (lit_idx_q == 3'd2);
      end
      2'd1: begin
        case (lit_idx_q)
          3'd0:    lit_char = "a";
          3'd1:    lit_char = "l";
          3'd2:    lit_char = "s";
          default: lit_char = "e";
        endcase
        lit_done = (lit_idx_q == 3'd3);
      end
      default: begin
        lit_char = (lit_idx_q == 3'd0) ? "u" : "l";
        lit_done = (lit_idx_q == 3'd2);
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    stack_d     = stack_q;
    depth_d     = depth_q;
    depth_max_d = depth_max_q;
    is_key_d    = is_key_q;
    lit_kind_d  = lit_kind_q;
    lit_idx_d   = lit_idx_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    code_d      = code_q;
    off_d       = off_q;
    st_valid_d  = st_valid_q;
    byte_err    = 1'b0;
    byte_code   = ST_OK;
    push        = 1'b0;
    push_obj    = 1'b0;
    push_state  = S_VALUE;
    end_code    = ST_INVALID;
    top_d       = 1'b0;

    // A byte that ends a number is reprocessed as AFTER; AFTER at depth 0 behaves as ROOT_DONE.
    eff0 = state_q;
    if (state_q == S_NUM && !is_num) eff0 = S_AFTER;
    if (eff0 == S_AFTER && depth_q == '0) eff0 = S_ROOT_DONE;
    eff = eff0;
    if (eff0 == S_KEY_OR_CLOSE && in_data != "}") eff = S_KEY;
    if (eff0 == S_VALUE_OR_CLOSE && in_data != "]") eff = S_VALUE;

    if (st_valid_q && st_ready) begin
      state_d     = S_VALUE;
      stack_d     = '0;
      depth_d     = '0;
      depth_max_d = '0;
      is_key_d    = 1'b0;
      lit_kind_d  = 2'd0;
      lit_idx_d   = 3'd0;
      cnt_d       = '0;
      err_d       = 1'b0;
      code_d      = ST_OK;
      off_d       = '0;
      st_valid_d  = 1'b0;
    end else if (accept) begin
      state_d = eff0;
      case (eff)
        S_VALUE: begin
          if (!is_ws) begin
            if (in_data == "{") begin
              push = 1'b1; push_obj = 1'b1; push_state = S_KEY_OR_CLOSE;
            end else if (in_data == "[") begin
              push = 1'b1; push_state = S_VALUE_OR_CLOSE;
            end else if (in_data == "\"") begin
              state_d = S_STR; is_key_d = 1'b0;
            end else if (in_data == "t" || in_data == "f" || in_data == "n") begin
              state_d    = S_LIT;
              lit_idx_d  = 3'd0;
              lit_kind_d = (in_data == "t") ? 2'd0 : (in_data == "f") ? 2'd1 : 2'd2;
            end else if (in_data == "-" || is_digit) begin
              state_d = S_NUM;
            end else begin
              byte_err = 1'b1; byte_code = ST_INVALID;
            end
          end
        end
        S_KEY_OR_CLOSE, S_VALUE_OR_CLOSE: begin
          depth_d = depth_q - D_ONE;
          state_d = S_AFTER;
        end
        S_KEY: begin
          if (in_data == "\"") begin
            state_d = S_STR; is_key_d = 1'b1;
          end else if (!is_ws) begin
            byte_err = 1'b1; byte_code = ST_MISS_KEY;
          end
        end
        S_STR: begin
          if (in_data == "\\") state_d = S_ESC;
          else if (in_data == "\"") state_d = is_key_q ? S_COLON : S_AFTER;
        end
        S_ESC: state_d = S_STR;
        S_COLON: begin
          if (in_data == ":") state_d = S_VALUE;
          else if (!is_ws) begin
            byte_err = 1'b1; byte_code = ST_MISS_COLON;
          end
        end
        S_LIT: begin
          if (in_data != lit_char) begin
            byte_err = 1'b1; byte_code = ST_INVALID;
          end else if (lit_done) state_d = S_AFTER;
          else lit_idx_d = lit_idx_q + 3'd1;
        end
        S_AFTER: begin
          if (in_data == ",") state_d = top_q ? S_KEY : S_VALUE;
          else if ((top_q && in_data == "}") || (!top_q && in_data == "]")) depth_d = depth_q - D_ONE;
          else if (!is_ws) begin
            byte_err = 1'b1; byte_code = top_q ? ST_MISS_CURLY : ST_MISS_SQUARE;
          end
        end
        S_ROOT_DONE: begin
          if (!is_ws) begin
            byte_err = 1'b1; byte_code = ST_ROOT;
          end
        end
        default: ;
      endcase

      if (push) begin
        if (depth_q == D_MAX) begin
          byte_err = 1'b1; byte_code = ST_DEPTH;
        end else begin
          stack_d = push_obj ? (stack_q | (STK_ONE << depth_q)) : (stack_q & ~(STK_ONE << depth_q));
          depth_d = depth_q + D_ONE;
          state_d = push_state;
          if (depth_d > depth_max_q) depth_max_d = depth_d;
        end
      end

      cnt_d = cnt_inc;
      top_d = |(stack_d & (STK_ONE << (depth_d - D_ONE)));
      if (state_d == S_ROOT_DONE || (depth_d == '0 && (state_d == S_AFTER || state_d == S_NUM)))
        end_code = ST_OK;
      else if (state_d == S_VALUE && depth_d == '0) end_code = ST_NO_VALUE;
      else if (state_d == S_STR || state_d == S_ESC) end_code = ST_MISS_QUOTE;
      else if (depth_d != '0) end_code = top_d ? ST_MISS_CURLY : ST_MISS_SQUARE;

      if (byte_err) begin
        err_d   = 1'b1;
        code_d  = byte_code;
        off_d   = cnt_q;
        state_d = S_DRAIN;
      end
      if (in_last) begin
        st_valid_d = 1'b1;
        if (!err_q && !byte_err) begin
          code_d = end_code;
          off_d  = cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_VALUE;
      stack_q     <= '0;
      depth_q     <= '0;
      depth_max_q <= '0;
      is_key_q    <= 1'b0;
      lit_kind_q  <= 2'd0;
      lit_idx_q   <= 3'd0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      code_q      <= ST_OK;
      off_q       <= '0;
      st_valid_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      depth_max_q <= depth_max_d;
      is_key_q    <= is_key_d;
      lit_kind_q  <= lit_kind_d;
      lit_idx_q   <= lit_idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      code_q      <= code_d;
      off_q       <= off_d;
      st_valid_q  <= st_valid_d;
      run_q       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_json_stream_checker.sv
// tb/tb_json_stream_checker.sv - table, corner-case and randomized document checks for json_stream_checker
module tb_json_stream_checker;

  localparam int MAX_DEPTH = 4;
  localparam int CNT_W     = 6;
  localparam int ST_W      = 4;
  localparam int DW        = $clog2(MAX_DEPTH + 1);
  localparam int SAT       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             st_valid;
  logic             st_ready;
  logic [ST_W-1:0]  st_code;
  logic [CNT_W-1:0] st_offset;
  logic [DW-1:0]    st_depth_max;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string doc;
    int    code;
    int    off;
    int    dmax;
  } vec_t;

  json_stream_checker #(.MAX_DEPTH(MAX_DEPTH), .CNT_W(CNT_W), .ST_W(ST_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .st_valid(st_valid), .st_ready(st_ready), .st_code(st_code),
    .st_offset(st_offset), .st_depth_max(st_depth_max)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string d, input int c, input int o, input int m);
    vec_t v;
    v.doc = d; v.code = c; v.off = o; v.dmax = m;
    return v;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  function automatic string pick_scalar(input int k);
    case (k)
      0:       return "1";
      1:       return "-2.5e3";
      2:       return "true";
      3:       return "false";
      4:       return "null";
      5:       return "\"ab\"";
      default: return "\"q\\\"z\"";
    endcase
  endfunction

  // Builds a well-formed document as a random tree; the construction itself yields the expected status.
  task automatic gen_doc(output string s, output int code, output int off, output int dmax);
    int typ[$];
    int rem[$];
    int first[$];
    int depth, deep_at, t, n;
    bit need;
    s = ""; depth = 0; dmax = 0; deep_at = -1; need = 1'b1;
    for (int step = 0; step < 2000; step++) begin
      if (need) begin
        if ($urandom_range(0, 1) == 1) s = {s, " "};
        if (depth < 6 && s.len() < 40 && $urandom_range(0, 2) == 0) begin
          t = int'($urandom_range(0, 1));
          if (t == 1) s = {s, "{"};
          else s = {s, "["};
          depth++;
          if (depth > dmax) dmax = depth;
          if (depth > MAX_DEPTH && deep_at < 0) deep_at = s.len() - 1;
          typ.push_back(t);
          rem.push_back(int'($urandom_range(0, 2)));
          first.push_back(1);
        end else begin
          s = {s, pick_scalar(int'($urandom_range(0, 6)))};
        end
        need = 1'b0;
      end else if (typ.size() == 0) begin
        break;
      end else begin
        n = typ.size() - 1;
        if (rem[n] == 0) begin
          if (typ[n] == 1) s = {s, "}"};
          else s = {s, "]"};
          void'(typ.pop_back()); void'(rem.pop_back()); void'(first.pop_back());
          depth--;
        end else begin
          if (first[n] == 0) s = {s, ","};
          first[n] = 0;
          rem[n] = rem[n] - 1;
          if (typ[n] == 1) s = {s, "\"k\":"};
          need = 1'b1;
        end
      end
    end
    if (deep_at >= 0) begin
      code = 10; off = deep_at; dmax = MAX_DEPTH;
    end else if ($urandom_range(0, 3) == 0) begin
      s = {s, " 7"}; code = 1; off = s.len() - 1;
    end else begin
      code = 0; off = s.len();
    end
  endtask

  task automatic run_doc(input string name, input string doc, input int exp_code, input int exp_off,
                         input int exp_dmax, input bit gaps);
    int g, k;
    bit early;
    early = 1'b0;
    for (int i = 0; i < doc.len(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      g = 0;
      while (!in_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (g >= 100) chk({name, " ready timeout"}, g, 0);
      if (st_valid) early = 1'b1;
      in_valid = 1'b1;
      in_data  = doc[i];
      in_last  = (i == doc.len() - 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({name, " early status"}, int'(early), 0);
    chk({name, " st_valid"}, int'(st_valid), 1);
    chk({name, " code"}, int'(st_code), exp_code);
    chk({name, " offset"}, int'(st_offset), exp_off);
    chk({name, " depth_max"}, int'(st_depth_max), exp_dmax);
    k = int'($urandom_range(0, 2));
    repeat (k) @(negedge clk);
    chk({name, " status held"}, int'(st_valid), 1);
    st_ready = 1'b1;
    @(negedge clk);
    st_ready = 1'b0;
    chk({name, " status cleared"}, int'(st_valid), 0);
  endtask

  initial begin
    vec_t  vecs[$];
    string s;
    int    c, o, m;

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; st_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset st_valid", int'(st_valid), 0);
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset st_code", int'(st_code), 0);
    chk("reset st_offset", int'(st_offset), 0);
    chk("reset depth_max", int'(st_depth_max), 0);
    rst_n = 1'b1;
    #1 chk("ready before first clk", int'(in_ready), 0);
    @(negedge clk);
    chk("ready after first clk", int'(in_ready), 1);

    vecs.push_back(mk("{\"a\":[1,true,null]}", 0, 19, 2));
    vecs.push_back(mk("{\"a\" 1}", 4, 5, 1));
    vecs.push_back(mk("[[[[[1]]]]]", 10, 4, 4));
    vecs.push_back(mk("\"ab\\\"c", 6, 6, 0));
    vecs.push_back(mk("  ", 8, 2, 0));
    vecs.push_back(mk("1 2", 1, 2, 0));
    vecs.push_back(mk("[1 2]", 7, 3, 1));
    vecs.push_back(mk("{\"a\":1 \"b\"}", 5, 7, 1));
    vecs.push_back(mk("tru e", 2, 3, 0));
    vecs.push_back(mk("{\"k\":-1.5e+3,\"x\":[]}", 0, 20, 2));
    vecs.push_back(mk("{}", 0, 2, 1));
    vecs.push_back(mk("{1}", 3, 1, 1));
    vecs.push_back(mk("[1,2", 7, 4, 1));
    vecs.push_back(mk("{\"a\":1", 5, 6, 1));
    vecs.push_back(mk("nul", 2, 3, 0));
    vecs.push_back(mk("x", 2, 0, 0));
    vecs.push_back(mk(" true ", 0, 6, 0));
    vecs.push_back(mk("{\"a\":{\"b\":[1]}}", 0, 15, 3));
    vecs.push_back(mk("[1]]", 1, 3, 1));
    vecs.push_back(mk("[1}", 7, 2, 1));
    for (int i = 0; i < vecs.size(); i++)
      run_doc($sformatf("vec%0d", i), vecs[i].doc, vecs[i].code, vecs[i].off, vecs[i].dmax, 1'b0);

    // Status back-pressure: a waiting byte must not be taken while the status is pending.
    in_valid = 1'b1; in_data = "5"; in_last = 1'b1;
    @(negedge clk);
    in_data = "x";
    for (int k = 0; k < 5; k++) begin
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp st_valid", int'(st_valid), 1);
      @(negedge clk);
    end
    chk("bp code", int'(st_code), 0);
    chk("bp offset", int'(st_offset), 1);
    in_valid = 1'b0; in_last = 1'b0; st_ready = 1'b1;
    @(negedge clk);
    st_ready = 1'b0;
    chk("bp released", int'(st_valid), 0);
    run_doc("after_bp", "[5]", 0, 3, 1, 1'b0);

    // Reset in the middle of a document.
    s = "{\"a\":[";
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1; in_data = s[i]; in_last = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst in_ready", int'(in_ready), 0);
    chk("midrst st_valid", int'(st_valid), 0);
    chk("midrst depth_max", int'(st_depth_max), 0);
    chk("midrst offset", int'(st_offset), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst ready held low", int'(in_ready), 0);
    @(negedge clk);
    chk("midrst ready up", int'(in_ready), 1);
    run_doc("post_reset", "{\"b\":[true]}", 0, 12, 2, 1'b0);

    // Offset saturation at 2^CNT_W-1.
    s = "";
    for (int i = 0; i < 70; i++) s = {s, " "};
    run_doc("sat_ok", {s, "1"}, 0, SAT, 0, 1'b0);
    run_doc("sat_err", {s, "]"}, 2, SAT, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      gen_doc(s, c, o, m);
      run_doc($sformatf("rnd%0d", n), s, c, sat(o), m, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
